// File: rtl/seven_seg_value_display.sv
// Samples a 16-bit value each refresh tick, sequences the BCD converter handshake, and drives
// four registered active-low 7-segment digits. Optional: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_value_display #(
    parameter int unsigned REFRESH_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    output logic        conv_start,
    output logic [15:0] conv_binary,
    input  logic [15:0] conv_digits,
    input  logic        conv_done,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        busy,
    output logic        overrange
);

    localparam int unsigned    CNT_W     = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [15:0]    MAX_BCD   = 16'd9999;
    localparam logic [6:0]     SEG_BLANK = 7'b1111111;
    localparam logic [6:0]     SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_LATCH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pending_q, pending_d;
    logic               wait_first_q, wait_first_d;
    logic               conv_start_q, conv_start_d;
    logic [15:0]        conv_binary_q, conv_binary_d;
    logic               busy_q, busy_d;
    logic               overrange_q, overrange_d;
    logic [6:0]         hex3_q, hex2_q, hex1_q, hex0_q;
    logic [6:0]         hex3_d, hex2_d, hex1_d, hex0_d;
    logic [6:0]         seg3_c, seg2_c, seg1_c, seg0_c;
    logic               tick_c;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // Converter digits to segment codes, with optional leading-zero suppression (hex0 never blanked)
    always_comb begin
        seg3_c = seg_decode(conv_digits[15:12]);
        seg2_c = seg_decode(conv_digits[11:8]);
        seg1_c = seg_decode(conv_digits[7:4]);
        seg0_c = seg_decode(conv_digits[3:0]);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        if (conv_digits[15:12] == 4'd0) begin
            seg3_c = SEG_BLANK;
            if (conv_digits[11:8] == 4'd0) begin
                seg2_c = SEG_BLANK;
                if (conv_digits[7:4] == 4'd0) begin
                    seg1_c = SEG_BLANK;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        wait_first_d  = 1'b0;
        conv_start_d  = 1'b0;
        conv_binary_d = conv_binary_q;
        busy_d        = busy_q;
        overrange_d   = overrange_q;
        hex3_d        = hex3_q;
        hex2_d        = hex2_q;
        hex1_d        = hex1_q;
        hex0_d        = hex0_q;

        tick_c = (cnt_q == '0);
        cnt_d  = tick_c ? CNT_MAX : cnt_q - CNT_W'(1);

        // A single tick is queued while an update is in flight
        if (tick_c && state_q != S_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_c || pending_q) begin
                    conv_binary_d = value;
                    pending_d     = 1'b0;
                    busy_d        = 1'b1;
                    if (value > MAX_BCD) begin
                        state_d = S_LATCH;
                    end else begin
                        state_d      = S_START;
                        conv_start_d = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d      = S_WAIT;
                wait_first_d = 1'b1;
            end
            S_WAIT: begin
                // done may still reflect the previous conversion during the first WAIT cycle
                if (!wait_first_q && conv_done) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (conv_binary_q > MAX_BCD) begin
                    overrange_d = 1'b1;
                    hex3_d      = SEG_DASH;
                    hex2_d      = SEG_DASH;
                    hex1_d      = SEG_DASH;
                    hex0_d      = SEG_DASH;
                end else begin
                    overrange_d = 1'b0;
                    hex3_d      = seg3_c;
                    hex2_d      = seg2_c;
                    hex1_d      = seg1_c;
                    hex0_d      = seg0_c;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            wait_first_q  <= 1'b0;
            conv_start_q  <= 1'b0;
            conv_binary_q <= '0;
            busy_q        <= 1'b0;
            overrange_q   <= 1'b0;
            hex3_q        <= SEG_BLANK;
            hex2_q        <= SEG_BLANK;
            hex1_q        <= SEG_BLANK;
            hex0_q        <= SEG_BLANK;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            wait_first_q  <= wait_first_d;
            conv_start_q  <= conv_start_d;
            conv_binary_q <= conv_binary_d;
            busy_q        <= busy_d;
            overrange_q   <= overrange_d;
            hex3_q        <= hex3_d;
            hex2_q        <= hex2_d;
            hex1_q        <= hex1_d;
            hex0_q        <= hex0_d;
        end
    end

    assign conv_start  = conv_start_q;
    assign conv_binary = conv_binary_q;
    assign busy        = busy_q;
    assign overrange   = overrange_q;
    assign hex3        = hex3_q;
    assign hex2        = hex2_q;
    assign hex1        = hex1_q;
    assign hex0        = hex0_q;

endmodule
